// File: rtl/arc_drawer.sv
// Midpoint circle engine with per-octant enable mask; one pixel candidate per clock to the VGA write port.
// Optional screen-bounds clipping is enabled by defining ARC_DRAWER_CLIP_EN.
module arc_drawer #(
    parameter int unsigned X_W   = 8,
    parameter int unsigned Y_W   = 7,
    parameter int unsigned R_W   = 8,
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           done,
    input  logic [X_W-1:0] centre_x,
    input  logic [Y_W-1:0] centre_y,
    input  logic [R_W-1:0] radius,
    input  logic [2:0]     colour,
    input  logic [7:0]     octant_mask,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot
);

    localparam int unsigned OW = R_W + 1;
    localparam int unsigned CW = R_W + 3;
    localparam int unsigned PW = ((X_W > Y_W) ? X_W : Y_W) + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_PLOT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef ARC_DRAWER_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    localparam logic signed [OW-1:0] O_ONE = OW'(1);
    localparam logic signed [CW-1:0] C_ONE = CW'(1);
    localparam logic signed [PW-1:0] X_LIM = PW'(X_MAX);
    localparam logic signed [PW-1:0] Y_LIM = PW'(Y_MAX);

    logic [1:0]            state_q, state_d;
    logic [X_W-1:0]        cx_q, cx_d;
    logic [Y_W-1:0]        cy_q, cy_d;
    logic [2:0]            colour_q, colour_d;
    logic [7:0]            mask_q, mask_d;
    logic signed [OW-1:0]  ox_q, ox_d;
    logic signed [OW-1:0]  oy_q, oy_d;
    logic signed [CW-1:0]  crit_q, crit_d;
    logic [2:0]            k_q, k_d;
    logic                  done_q, done_d;
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [2:0]            vga_colour_q, vga_colour_d;
    logic                  vga_plot_q, vga_plot_d;

    logic signed [OW-1:0]  ox_n, oy_n;
    logic signed [PW-1:0]  cx_s, cy_s, ox_s, oy_s, px, py;
    logic                  out_of_bounds;

    // Next-state, step arithmetic, and the pixel for the upcoming cycle (outputs track state_d so they
    // are valid during the PLOT cycle they belong to).
    always_comb begin
        state_d       = state_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        colour_d      = colour_q;
        mask_d        = mask_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        crit_d        = crit_q;
        k_d           = k_q;
        ox_n          = ox_q;
        oy_n          = oy_q;
        done_d        = 1'b0;
        vga_x_d       = '0;
        vga_y_d       = '0;
        vga_colour_d  = '0;
        vga_plot_d    = 1'b0;
        px            = '0;
        py            = '0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_INIT;
            end
            S_INIT: begin
                cx_d     = centre_x;
                cy_d     = centre_y;
                colour_d = colour;
                mask_d   = octant_mask;
                ox_d     = OW'(radius);
                oy_d     = '0;
                crit_d   = C_ONE - CW'(radius);
                k_d      = 3'd0;
                state_d  = S_PLOT;
            end
            S_PLOT: begin
                if (k_q == 3'd7) begin
                    oy_n = oy_q + O_ONE;
                    if (crit_q[CW-1] || (crit_q == '0)) begin
                        ox_n   = ox_q;
                        crit_d = crit_q + (CW'(oy_n) <<< 1) + C_ONE;
                    end else begin
                        ox_n   = ox_q - O_ONE;
                        crit_d = crit_q + ((CW'(oy_n) - CW'(ox_n)) <<< 1) + C_ONE;
                    end
                    ox_d = ox_n;
                    oy_d = oy_n;
                    k_d  = 3'd0;
                    if (oy_n > ox_n) state_d = S_DONE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            default: begin
                if (!start) state_d = S_IDLE;
            end
        endcase

        cx_s = PW'(cx_d);
        cy_s = PW'(cy_d);
        ox_s = PW'(ox_d);
        oy_s = PW'(oy_d);

        // Octant order: 0..3 lower half (y grows down), 4..7 upper half, counter-rotating around centre.
        case (k_d)
            3'd0: begin px = cx_s + ox_s; py = cy_s + oy_s; end
            3'd1: begin px = cx_s + oy_s; py = cy_s + ox_s; end
            3'd2: begin px = cx_s - oy_s; py = cy_s + ox_s; end
            3'd3: begin px = cx_s - ox_s; py = cy_s + oy_s; end
            3'd4: begin px = cx_s - ox_s; py = cy_s - oy_s; end
            3'd5: begin px = cx_s - oy_s; py = cy_s - ox_s; end
            3'd6: begin px = cx_s + oy_s; py = cy_s - ox_s; end
            default: begin px = cx_s + ox_s; py = cy_s - oy_s; end
        endcase

        out_of_bounds = px[PW-1] || (px > X_LIM) || py[PW-1] || (py > Y_LIM);

        if (state_d == S_PLOT) begin
            vga_x_d      = px[X_W-1:0];
            vga_y_d      = py[Y_W-1:0];
            vga_colour_d = colour_d;
            vga_plot_d   = mask_d[k_d] && !(CLIP_EN && out_of_bounds);
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            colour_q     <= '0;
            mask_q       <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            crit_q       <= '0;
            k_q          <= '0;
            done_q       <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            colour_q     <= colour_d;
            mask_q       <= mask_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            crit_q       <= crit_d;
            k_q          <= k_d;
            done_q       <= done_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign done       = done_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_arc_drawer.sv
// Bench for arc_drawer: integer midpoint-circle reference, per-cycle output comparison, geometric checks.
module tb_arc_drawer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       done;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic [7:0] octant_mask;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int checks   = 0;
    int failures = 0;

    // {done, x, y, colour, plot} expected for each PLOT cycle
    logic [19:0] exp_q[$];

    arc_drawer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .done       (done),
        .centre_x   (centre_x),
        .centre_y   (centre_y),
        .radius     (radius),
        .colour     (colour),
        .octant_mask(octant_mask),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Walk the circle with plain integers; one entry per candidate in emission order.
    task automatic build_model(input int cx, input int cy, input int r,
                               input logic [2:0] col, input logic [7:0] mask);
        int ox, oy, d, px, py;
        logic pl;
        exp_q.delete();
        ox = r; oy = 0; d = 1 - r;
        do begin
            for (int k = 0; k < 8; k++) begin
                case (k)
                    0: begin px = cx + ox; py = cy + oy; end
                    1: begin px = cx + oy; py = cy + ox; end
                    2: begin px = cx - oy; py = cy + ox; end
                    3: begin px = cx - ox; py = cy + oy; end
                    4: begin px = cx - ox; py = cy - oy; end
                    5: begin px = cx - oy; py = cy - ox; end
                    6: begin px = cx + oy; py = cy - ox; end
                    default: begin px = cx + ox; py = cy - oy; end
                endcase
                pl = mask[k];
`ifdef ARC_DRAWER_CLIP_EN
                if (px < 0 || px > 159 || py < 0 || py > 119) pl = 1'b0;
`endif
                exp_q.push_back({1'b0, 8'(px), 7'(py), col, pl});
            end
            oy = oy + 1;
            if (d <= 0) d = d + 2 * oy + 1;
            else begin
                ox = ox - 1;
                d  = d + 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    // geo: 0 none, 1 circle tolerance, 2 octant-0 region; exp_plots < 0 skips plot-count check
    task automatic run_draw(input int cx, input int cy, input int r, input logic [2:0] col,
                            input logic [7:0] mask, input bit drop_start, input int geo,
                            input int exp_plots);
        int n, plots, p246, e246, dx, dy, e;
        logic [19:0] obs;
        build_model(cx, cy, r, col, mask);
        n = exp_q.size();
        plots = 0; p246 = 0; e246 = 0;
        foreach (exp_q[i]) if (exp_q[i][0] && exp_q[i][18:11] == 8'd246) e246++;

        @(negedge clk);
        centre_x = 8'(cx); centre_y = 7'(cy); radius = 8'(r);
        colour = col; octant_mask = mask; start = 1'b1;
        @(posedge clk); #1;
        chk("init_idle_outputs", 32'({done, vga_plot}), 32'd0);

        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                if (drop_start) start = 1'b0;
                centre_x = 8'($urandom); centre_y = 7'($urandom); radius = 8'($urandom);
                colour = 3'($urandom); octant_mask = 8'($urandom);
            end
            obs = {done, vga_x, vga_y, vga_colour, vga_plot};
            chk($sformatf("pixel[%0d]", i), 32'(obs), 32'(exp_q[i]));
            if (vga_plot) begin
                plots++;
                if (vga_x == 8'd246) p246++;
                dx = int'(vga_x) - cx;
                dy = int'(vga_y) - cy;
                if (geo == 1) begin
                    e = dx * dx + dy * dy - r * r;
                    chk("circle_tol", 32'(e >= -r && e <= r), 32'd1);
                end else if (geo == 2) begin
                    chk("octant0_region", 32'(dx >= 0 && dy >= 0 && dy <= dx), 32'd1);
                end
            end
        end

        @(posedge clk); #1;
        chk("done_rise", 32'({done, vga_plot}), 32'b10);
        if (!drop_start) begin
            @(posedge clk); #1;
            chk("done_held", 32'(done), 32'd1);
            start = 1'b0;
        end
        @(posedge clk); #1;
        chk("done_drop", 32'(done), 32'd0);
        if (exp_plots >= 0) chk("plot_count", 32'(plots), 32'(exp_plots));
        chk("plots_at_246", 32'(p246), 32'(e246));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        centre_x = '0; centre_y = '0; radius = '0; colour = '0; octant_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({done, vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // radius 0: eight coincident candidates, N=1
        run_draw(80, 60, 0, 3'd5, 8'hFF, 1'b0, 0, 8);
        // radius 1: two steps
        run_draw(80, 60, 1, 3'd2, 8'hFF, 1'b0, 1, 16);
        // radius 40 full circle, then octant 0 only with identical timing
        run_draw(80, 60, 40, 3'd7, 8'hFF, 1'b0, 1, -1);
        run_draw(80, 60, 40, 3'd1, 8'h01, 1'b0, 2, -1);
        // corner centre exercises clipping / wraparound
        run_draw(0, 0, 10, 3'd3, 8'hFF, 1'b0, 0, -1);
        // start released in the first PLOT cycle
        run_draw(50, 40, 7, 3'd6, 8'hA5, 1'b1, 0, -1);

        // reset in the middle of a draw
        @(negedge clk);
        centre_x = 8'd80; centre_y = 7'd60; radius = 8'd40; colour = 3'd4;
        octant_mask = 8'hFF; start = 1'b1;
        repeat (2 + 8 * 5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset_outputs", 32'({done, vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
        @(negedge clk); rst_n = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        chk("midreset_idle", 32'({done, vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
        run_draw(80, 60, 5, 3'd2, 8'hFF, 1'b0, 1, -1);

        // randomized draws
        for (int t = 0; t < 4; t++) begin
            run_draw(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
                     int'($urandom_range(0, 60)), 3'($urandom), 8'($urandom),
                     1'($urandom), 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
